// File: rtl/raw_rgb_pkg.sv
// rtl/raw_rgb_pkg.sv - shared types and constants for the Bayer demosaic/binning path
// Purpose: CFA phase and colour-site enums, white-balance fixed-point constant,
//          and the site decoder shared by the demosaic top.
// Ports:   none (package).
package raw_rgb_pkg;

  typedef enum logic [1:0] {
    PH_RGGB = 2'b00,
    PH_GRBG = 2'b01,
    PH_GBRG = 2'b10,
    PH_BGGR = 2'b11
  } cfa_phase_t;

  // Colour of the sample currently on D0.
  typedef enum logic [1:0] {
    SITE_R  = 2'b00,
    SITE_GR = 2'b01,
    SITE_GB = 2'b10,
    SITE_B  = 2'b11
  } site_t;

  // Gains are unsigned fixed point; 1 << WB_FRAC is unity.
  localparam int WB_FRAC = 7;

  // The phase bits simply flip the row/column parity of the RGGB tiling.
  function automatic site_t site_of(input logic y0, input logic x0, input cfa_phase_t ph);
    return site_t'({y0 ^ ph[1], x0 ^ ph[0]});
  endfunction

endpackage

// File: rtl/raw_rgb_wb_gain.sv
// rtl/raw_rgb_wb_gain.sv - one-channel white-balance multiply, saturate and register
// Purpose: q <= min((c * gain) >> WB_FRAC, 2^DW-1), loaded only when en is high.
// Ports:   CLK, RESET (sync, active-high), en (load strobe),
//          c [DW] input sample, gain [GW] fixed-point gain, q [DW] registered result.
module raw_rgb_wb_gain
  import raw_rgb_pkg::*;
#(
  parameter int DW = 10,
  parameter int GW = 8
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          en,
  input  logic [DW-1:0] c,
  input  logic [GW-1:0] gain,
  output logic [DW-1:0] q
);

  localparam int PW = DW + GW;

  logic [PW-1:0] prod;
  logic [PW-1:0] scaled;
  logic [DW-1:0] sat;

  assign prod   = PW'(c) * PW'(gain);
  assign scaled = prod >> WB_FRAC;
  // Anything above full scale clips to full scale rather than wrapping.
  assign sat    = (scaled > PW'({DW{1'b1}})) ? {DW{1'b1}} : scaled[DW-1:0];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      q <= '0;
    end else if (en) begin
      q <= sat;
    end
  end

endmodule

// File: rtl/raw_rgb_demosaic_bin.sv
// rtl/raw_rgb_demosaic_bin.sv - streaming 2x2 Bayer-to-RGB demosaic with X/Y tracking
// Purpose: takes the current-row pixel (D0) and the same column of the row above (D1),
//          keeps the previous column of both, and forms RGB from the 2x2 window.
//          Edge pixels replicate the nearest real sample. Optional white-balance
//          stage enabled by defining RAW_RGB_WB_GAIN_EN (adds one cycle of latency).
// Ports:   CLK, RESET (sync, active-high)
//          IN_VALID, IN_SOF, IN_EOL, D0 [DW], D1 [DW], BAYER_PHASE [2]
//          WB_R, WB_G, WB_B [GW] gains (used only with RAW_RGB_WB_GAIN_EN)
//          OUT_VALID, OUT_SOF, OUT_EOL, R, G, B [DW], X_CNT, Y_CNT [XW]
module raw_rgb_demosaic_bin
  import raw_rgb_pkg::*;
#(
  parameter int DW = 10,
  parameter int XW = 12,
  parameter int GW = 8
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          IN_VALID,
  input  logic          IN_SOF,
  input  logic          IN_EOL,
  input  logic [DW-1:0] D0,
  input  logic [DW-1:0] D1,
  input  logic [1:0]    BAYER_PHASE,
  input  logic [GW-1:0] WB_R,
  input  logic [GW-1:0] WB_G,
  input  logic [GW-1:0] WB_B,
  output logic          OUT_VALID,
  output logic          OUT_SOF,
  output logic          OUT_EOL,
  output logic [DW-1:0] R,
  output logic [DW-1:0] G,
  output logic [DW-1:0] B,
  output logic [XW-1:0] X_CNT,
  output logic [XW-1:0] Y_CNT
);

  // Position the next accepted pixel will take if it is not an SOF.
  logic [XW-1:0] x_nxt, y_nxt;
  cfa_phase_t    ph_q;
  logic [DW-1:0] rd0, rd1;

  // Current pixel coordinates/phase, with SOF overriding the running state.
  logic [XW-1:0] x_cur, y_cur, x_inc, y_inc;
  cfa_phase_t    ph_cur;
  site_t         site;

  // Edge-resolved 2x2 window: cur/left on this row, up/diag on the row above.
  logic [DW-1:0] w_cur, w_left, w_up, w_diag, w_ul_row;
  logic [DW:0]   sum_lu, sum_cd;
  logic [DW-1:0] avg_lu, avg_cd;
  logic [DW-1:0] r_c, g_c, b_c;

  // First output stage.
  logic          s1_valid, s1_sof, s1_eol;
  logic [DW-1:0] s1_r, s1_g, s1_b;
  logic [XW-1:0] s1_x, s1_y;

  always_comb begin
    x_cur  = IN_SOF ? '0 : x_nxt;
    y_cur  = IN_SOF ? '0 : y_nxt;
    ph_cur = IN_SOF ? cfa_phase_t'(BAYER_PHASE) : ph_q;
    // Saturate rather than wrap so oversize lines/frames stay at the last coordinate.
    x_inc  = (x_cur == {XW{1'b1}}) ? x_cur : x_cur + 1'b1;
    y_inc  = (y_cur == {XW{1'b1}}) ? y_cur : y_cur + 1'b1;
  end

  always_comb begin
    w_cur    = D0;
    w_left   = (x_cur == '0) ? D0 : rd0;
    w_ul_row = (x_cur == '0) ? D1 : rd1;
    // On the top row D1 is whatever the line buffer holds, so mirror the current row.
    w_up     = (y_cur == '0) ? D0 : D1;
    w_diag   = (y_cur == '0) ? w_left : w_ul_row;
    sum_lu   = {1'b0, w_left} + {1'b0, w_up};
    sum_cd   = {1'b0, w_cur} + {1'b0, w_diag};
    avg_lu   = sum_lu[DW:1];
    avg_cd   = sum_cd[DW:1];
    site     = site_of(y_cur[0], x_cur[0], ph_cur);
  end

  always_comb begin
    r_c = w_cur;
    g_c = avg_lu;
    b_c = w_diag;
    unique case (site)
      SITE_R: begin
        r_c = w_cur;
        b_c = w_diag;
        g_c = avg_lu;
      end
      SITE_B: begin
        b_c = w_cur;
        r_c = w_diag;
        g_c = avg_lu;
      end
      SITE_GR: begin
        r_c = w_left;
        b_c = w_up;
        g_c = avg_cd;
      end
      SITE_GB: begin
        b_c = w_left;
        r_c = w_up;
        g_c = avg_cd;
      end
      default: begin
        r_c = w_cur;
        g_c = avg_lu;
        b_c = w_diag;
      end
    endcase
  end

  // Tracking state moves only on accepted pixels; idle cycles leave it untouched.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      x_nxt <= '0;
      y_nxt <= '0;
      ph_q  <= PH_RGGB;
      rd0   <= '0;
      rd1   <= '0;
    end else if (IN_VALID) begin
      rd0 <= D0;
      rd1 <= D1;
      if (IN_SOF) begin
        ph_q <= cfa_phase_t'(BAYER_PHASE);
      end
      if (IN_EOL) begin
        x_nxt <= '0;
        y_nxt <= y_inc;
      end else begin
        x_nxt <= x_inc;
        y_nxt <= y_cur;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      s1_valid <= 1'b0;
      s1_sof   <= 1'b0;
      s1_eol   <= 1'b0;
      s1_r     <= '0;
      s1_g     <= '0;
      s1_b     <= '0;
      s1_x     <= '0;
      s1_y     <= '0;
    end else begin
      s1_valid <= IN_VALID;
      s1_sof   <= IN_VALID & IN_SOF;
      s1_eol   <= IN_VALID & IN_EOL;
      if (IN_VALID) begin
        s1_r <= r_c;
        s1_g <= g_c;
        s1_b <= b_c;
        s1_x <= x_cur;
        s1_y <= y_cur;
      end
    end
  end

`ifdef RAW_RGB_WB_GAIN_EN
  logic          s2_valid, s2_sof, s2_eol;
  logic [XW-1:0] s2_x, s2_y;
  logic [DW-1:0] s2_r, s2_g, s2_b;

  raw_rgb_wb_gain #(.DW(DW), .GW(GW)) u_gain_r (
    .CLK(CLK), .RESET(RESET), .en(s1_valid), .c(s1_r), .gain(WB_R), .q(s2_r)
  );
  raw_rgb_wb_gain #(.DW(DW), .GW(GW)) u_gain_g (
    .CLK(CLK), .RESET(RESET), .en(s1_valid), .c(s1_g), .gain(WB_G), .q(s2_g)
  );
  raw_rgb_wb_gain #(.DW(DW), .GW(GW)) u_gain_b (
    .CLK(CLK), .RESET(RESET), .en(s1_valid), .c(s1_b), .gain(WB_B), .q(s2_b)
  );

  // Sideband and coordinates follow the gain stage so they stay aligned with data.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      s2_valid <= 1'b0;
      s2_sof   <= 1'b0;
      s2_eol   <= 1'b0;
      s2_x     <= '0;
      s2_y     <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_sof   <= s1_sof;
      s2_eol   <= s1_eol;
      if (s1_valid) begin
        s2_x <= s1_x;
        s2_y <= s1_y;
      end
    end
  end

  assign OUT_VALID = s2_valid;
  assign OUT_SOF   = s2_sof;
  assign OUT_EOL   = s2_eol;
  assign R         = s2_r;
  assign G         = s2_g;
  assign B         = s2_b;
  assign X_CNT     = s2_x;
  assign Y_CNT     = s2_y;
`else
  // Gains have no effect in this build.
  logic unused_wb;
  assign unused_wb = ^{WB_R, WB_G, WB_B};

  assign OUT_VALID = s1_valid;
  assign OUT_SOF   = s1_sof;
  assign OUT_EOL   = s1_eol;
  assign R         = s1_r;
  assign G         = s1_g;
  assign B         = s1_b;
  assign X_CNT     = s1_x;
  assign Y_CNT     = s1_y;
`endif

endmodule

// File: tb/tb_raw_rgb_demosaic_bin.sv
// tb/tb_raw_rgb_demosaic_bin.sv - randomized image-model bench for raw_rgb_demosaic_bin
module tb_raw_rgb_demosaic_bin;

  localparam int DW   = 10;
  localparam int XW   = 12;
  localparam int GW   = 8;
  localparam int MAXC = 4095;
  localparam int MAXV = 1023;
`ifdef RAW_RGB_WB_GAIN_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          CLK;
  logic          RESET;
  logic          IN_VALID, IN_SOF, IN_EOL;
  logic [DW-1:0] D0, D1;
  logic [1:0]    BAYER_PHASE;
  logic [GW-1:0] WB_R, WB_G, WB_B;
  logic          OUT_VALID, OUT_SOF, OUT_EOL;
  logic [DW-1:0] R, G, B;
  logic [XW-1:0] X_CNT, Y_CNT;

  raw_rgb_demosaic_bin #(.DW(DW), .XW(XW), .GW(GW)) dut (
    .CLK(CLK), .RESET(RESET),
    .IN_VALID(IN_VALID), .IN_SOF(IN_SOF), .IN_EOL(IN_EOL),
    .D0(D0), .D1(D1), .BAYER_PHASE(BAYER_PHASE),
    .WB_R(WB_R), .WB_G(WB_G), .WB_B(WB_B),
    .OUT_VALID(OUT_VALID), .OUT_SOF(OUT_SOF), .OUT_EOL(OUT_EOL),
    .R(R), .G(G), .B(B), .X_CNT(X_CNT), .Y_CNT(Y_CNT)
  );

  typedef struct {
    int r; int g; int b; int x; int y; int sof; int eol; int cyc;
  } exp_t;

  exp_t expq[$];
  int   img[8192];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic rst_q = 1'b1;
  int   row0_d1 = -1;
  int   last_r = 0, last_g = 0, last_b = 0, last_x = 0, last_y = 0;
  int   cap_r[16], cap_g[16], cap_b[16];
  int   sav_r[16], sav_g[16], sav_b[16];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    cyc   <= cyc + 1;
    rst_q <= RESET;
  end

  task automatic check(input string tag, input int obs, input int exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  function automatic int apply_gain(input int c, input int wb);
`ifdef RAW_RGB_WB_GAIN_EN
    int v;
    v = (c * wb) >> 7;
    return (v > MAXV) ? MAXV : v;
`else
    return c + 0 * wb;
`endif
  endfunction

  // Output monitor: every valid output must match the oldest expected pixel,
  // arrive exactly LAT cycles after acceptance, and idle cycles must hold data.
  always @(negedge CLK) begin
    exp_t e;
    if (rst_q) begin
      check("rst_out", int'(OUT_VALID | OUT_SOF | OUT_EOL | (|R) | (|G) | (|B) | (|X_CNT) | (|Y_CNT)), 0);
      last_r = 0; last_g = 0; last_b = 0; last_x = 0; last_y = 0;
    end else if (OUT_VALID) begin
      if (expq.size() == 0) begin
        check("spurious_valid", 1, 0);
      end else begin
        e = expq.pop_front();
        check("latency", cyc, e.cyc + LAT - 1);
        check("R", int'(R), e.r);
        check("G", int'(G), e.g);
        check("B", int'(B), e.b);
        check("X_CNT", int'(X_CNT), e.x);
        check("Y_CNT", int'(Y_CNT), e.y);
        check("OUT_SOF", int'(OUT_SOF), e.sof);
        check("OUT_EOL", int'(OUT_EOL), e.eol);
      end
      if (X_CNT < 4 && Y_CNT < 4) begin
        cap_r[Y_CNT * 4 + X_CNT] = int'(R);
        cap_g[Y_CNT * 4 + X_CNT] = int'(G);
        cap_b[Y_CNT * 4 + X_CNT] = int'(B);
      end
      last_r = R; last_g = G; last_b = B; last_x = X_CNT; last_y = Y_CNT;
    end else begin
      check("hold_rgb", int'({R, G, B}), (last_r << 20) | (last_g << 10) | last_b);
      check("hold_xy", int'({X_CNT, Y_CNT}), (last_x << 12) | last_y);
      check("idle_sideband", int'({OUT_SOF, OUT_EOL}), 0);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
      IN_VALID    = 1'b0;
      IN_SOF      = 1'($urandom);
      IN_EOL      = 1'($urandom);
      D0          = DW'($urandom);
      D1          = DW'($urandom);
      BAYER_PHASE = 2'($urandom);
    end
  endtask

  // Streams img (w x h, row-major) as one frame. gap < 0 means random 0..2 idle
  // cycles between pixels. Stops early after maxpix pixels (truncated frame).
  task automatic send_frame(input int w, input int h, input int ph, input int gap, input int maxpix);
    int n = 0;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        int cur, lf, up, dg, xx, yy, s, er, eg, eb, g;
        exp_t e;
        if (n == maxpix) return;
        n++;
        // 2x2 window with out-of-image neighbours clamped to the nearest real pixel.
        cur = img[r * w + c];
        lf  = (c == 0) ? cur : img[r * w + c - 1];
        up  = (r == 0) ? cur : img[(r - 1) * w + c];
        dg  = img[((r == 0) ? 0 : r - 1) * w + ((c == 0) ? 0 : c - 1)];
        xx  = (c > MAXC) ? MAXC : c;
        yy  = (r > MAXC) ? MAXC : r;
        s   = (((yy & 1) ^ ((ph >> 1) & 1)) << 1) | ((xx & 1) ^ (ph & 1));
        case (s)
          0:       begin er = cur; eb = dg;  eg = (lf + up) / 2;  end
          3:       begin eb = cur; er = dg;  eg = (lf + up) / 2;  end
          1:       begin er = lf;  eb = up;  eg = (cur + dg) / 2; end
          default: begin eb = lf;  er = up;  eg = (cur + dg) / 2; end
        endcase
        e.r = apply_gain(er, int'(WB_R));
        e.g = apply_gain(eg, int'(WB_G));
        e.b = apply_gain(eb, int'(WB_B));
        e.x = xx;
        e.y = yy;
        e.sof = (r == 0 && c == 0) ? 1 : 0;
        e.eol = (c == w - 1) ? 1 : 0;
        @(posedge CLK);
        #1;
        IN_VALID    = 1'b1;
        IN_SOF      = 1'(e.sof);
        IN_EOL      = 1'(e.eol);
        D0          = DW'(cur);
        D1          = (r == 0) ? ((row0_d1 >= 0) ? DW'(row0_d1) : DW'($urandom)) : DW'(up);
        BAYER_PHASE = (e.sof != 0) ? 2'(ph) : 2'($urandom);
        e.cyc = cyc + 1;
        expq.push_back(e);
        g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
        if (g > 0) idle(g);
      end
    end
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) img[i] = int'($urandom_range(0, MAXV));
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) img[r * 4 + c] = r * 16 + c;
  endtask

  initial begin
    RESET = 1'b1;
    IN_VALID = 1'b0; IN_SOF = 1'b0; IN_EOL = 1'b0;
    D0 = '0; D1 = '0; BAYER_PHASE = 2'b00;
    WB_R = 8'h80; WB_G = 8'h80; WB_B = 8'h80;
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0;
    idle(2);

    // 4x4 ramp, phase RGGB, dense.
    fill_ramp();
    send_frame(4, 4, 0, 0, -1);
    idle(3);
    check("ramp_11_B", cap_b[5], 17);
    check("ramp_11_R", cap_r[5], 0);
    check("ramp_11_G", cap_g[5], 8);
    for (int i = 0; i < 16; i++) begin
      sav_r[i] = cap_r[i]; sav_g[i] = cap_g[i]; sav_b[i] = cap_b[i];
    end

    // Same frame in BGGR: red and blue trade places, green does not move.
    send_frame(4, 4, 3, 0, -1);
    idle(3);
    for (int i = 0; i < 16; i++) begin
      check("bggr_swap_R", cap_r[i], sav_b[i]);
      check("bggr_swap_B", cap_b[i], sav_r[i]);
      check("bggr_same_G", cap_g[i], sav_g[i]);
    end

    // Same frame with 1-on/2-off valid pattern must produce identical pixels.
    send_frame(4, 4, 0, 2, -1);
    idle(3);
    for (int i = 0; i < 16; i++) begin
      check("gapped_R", cap_r[i], sav_r[i]);
      check("gapped_G", cap_g[i], sav_g[i]);
      check("gapped_B", cap_b[i], sav_b[i]);
    end

    // Top-left corner replication.
    row0_d1 = 900;
    img[0] = 100; img[1] = 300; img[2] = 500; img[3] = 700;
    send_frame(2, 2, 0, 0, -1);
    idle(3);
    row0_d1 = -1;
    check("corner_R", cap_r[0], 100);
    check("corner_G", cap_g[0], 100);
    check("corner_B", cap_b[0], 100);

    // Random frames with random phase, gaps and gains.
    for (int f = 0; f < 6; f++) begin
      int w, h;
      w = int'($urandom_range(1, 9));
      h = int'($urandom_range(1, 6));
      WB_R = 8'($urandom); WB_G = 8'($urandom); WB_B = 8'($urandom);
      fill_random(w * h);
      send_frame(w, h, int'($urandom_range(0, 3)), -1, -1);
      idle(int'($urandom_range(0, 3)));
    end
    WB_R = 8'h80; WB_G = 8'h80; WB_B = 8'h80;
    idle(3);

    // SOF arriving mid-line restarts coordinates.
    fill_random(18);
    send_frame(6, 3, 1, -1, 8);
    fill_random(10);
    send_frame(5, 2, 2, -1, -1);
    idle(3);

    // Reset in the middle of a line drops in-flight pixels.
    fill_random(16);
    send_frame(8, 2, 0, 0, 5);
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    IN_VALID = 1'b0;
    @(posedge CLK);
    #1;
    expq.delete();
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    idle(2);
    fill_random(12);
    send_frame(4, 3, 2, -1, -1);
    idle(3);

    // Long line: X_CNT saturates.
    fill_random(4100);
    send_frame(4100, 1, 0, 0, -1);
    idle(3);

    // One-pixel lines: SOF and EOL together, Y_CNT saturates.
    fill_random(4100);
    send_frame(1, 4100, 3, 0, -1);
    idle(3);

`ifdef RAW_RGB_WB_GAIN_EN
    // Gain saturation and unity gain on a single R-site pixel.
    WB_R = 8'hFF; WB_G = 8'hFF; WB_B = 8'hFF;
    img[0] = 700;
    send_frame(1, 1, 0, 0, -1);
    idle(4);
    check("gain_sat_R", cap_r[0], MAXV);
    WB_R = 8'h80; WB_G = 8'h80; WB_B = 8'h80;
    send_frame(1, 1, 0, 0, -1);
    idle(4);
    check("gain_unity_R", cap_r[0], 700);
`endif

    idle(4);
    check("drain", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
